// File: rtl/call_ret_ctrl.sv
// CALL/RET sequencer driving an external return stack and the core PC/flags.
// Optional macro STACK_GUARD_EN: RET on an empty stack faults instead of popping.
module call_ret_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       call_req,
    input  logic       ret_req,
    input  logic [8:0] call_target,
    input  logic [8:0] pc,
    input  logic [3:0] flags,
    input  logic [8:0] stk_top_pc,
    input  logic [3:0] stk_top_flags,
    output logic       push_en,
    output logic       pop_en,
    output logic [8:0] stk_pc,
    output logic [3:0] stk_flags,
    output logic       pc_load,
    output logic [8:0] pc_next,
    output logic       flags_load,
    output logic [3:0] flags_next,
    output logic       busy,
    output logic       done,
    output logic [2:0] depth,
    output logic       fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALL,
        S_RET_POP,
        S_RET_LOAD
    } state_t;

    localparam logic [2:0] DEPTH_MAX = 3'd5;

    state_t     state_q, state_d;
    logic       push_en_q, push_en_d;
    logic       pop_en_q, pop_en_d;
    logic [8:0] stk_pc_q, stk_pc_d;
    logic [3:0] stk_flags_q, stk_flags_d;
    logic       pc_load_q, pc_load_d;
    logic [8:0] pc_next_q, pc_next_d;
    logic       flags_load_q, flags_load_d;
    logic [3:0] flags_next_q, flags_next_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] depth_q, depth_d;
    logic       fault_q, fault_d;
    logic       ret_bad_q, ret_bad_d;

    always_comb begin
        state_d      = state_q;
        push_en_d    = 1'b0;
        pop_en_d     = 1'b0;
        stk_pc_d     = stk_pc_q;
        stk_flags_d  = stk_flags_q;
        pc_load_d    = 1'b0;
        pc_next_d    = pc_next_q;
        flags_load_d = 1'b0;
        flags_next_d = flags_next_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        depth_d      = depth_q;
        fault_d      = 1'b0;
        ret_bad_d    = ret_bad_q;

        unique case (state_q)
            S_IDLE: begin
                // CALL has priority; a simultaneous RET is dropped
                if (call_req) begin
                    state_d     = S_CALL;
                    busy_d      = 1'b1;
                    push_en_d   = 1'b1;
                    pc_load_d   = 1'b1;
                    done_d      = 1'b1;
                    stk_pc_d    = pc + 9'd1;
                    stk_flags_d = flags;
                    pc_next_d   = call_target;
                    if (depth_q != DEPTH_MAX) depth_d = depth_q + 3'd1;
                end else if (ret_req) begin
                    state_d   = S_RET_POP;
                    busy_d    = 1'b1;
                    ret_bad_d = 1'b0;
`ifdef STACK_GUARD_EN
                    if (depth_q == 3'd0) begin
                        fault_d   = 1'b1;
                        ret_bad_d = 1'b1;
                    end else begin
                        pop_en_d = 1'b1;
                        depth_d  = depth_q - 3'd1;
                    end
`else
                    pop_en_d = 1'b1;
                    if (depth_q != 3'd0) depth_d = depth_q - 3'd1;
`endif
                end
            end
            S_CALL: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            S_RET_POP: begin
                // stk_top still shows the pre-pop entry on this edge
                state_d = S_RET_LOAD;
                busy_d  = 1'b1;
                done_d  = 1'b1;
                if (!ret_bad_q) begin
                    pc_next_d    = stk_top_pc;
                    flags_next_d = stk_top_flags;
                    pc_load_d    = 1'b1;
                    flags_load_d = 1'b1;
                end
            end
            S_RET_LOAD: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                ret_bad_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            push_en_q    <= 1'b0;
            pop_en_q     <= 1'b0;
            stk_pc_q     <= '0;
            stk_flags_q  <= '0;
            pc_load_q    <= 1'b0;
            pc_next_q    <= '0;
            flags_load_q <= 1'b0;
            flags_next_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            depth_q      <= '0;
            fault_q      <= 1'b0;
            ret_bad_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            push_en_q    <= push_en_d;
            pop_en_q     <= pop_en_d;
            stk_pc_q     <= stk_pc_d;
            stk_flags_q  <= stk_flags_d;
            pc_load_q    <= pc_load_d;
            pc_next_q    <= pc_next_d;
            flags_load_q <= flags_load_d;
            flags_next_q <= flags_next_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            depth_q      <= depth_d;
            fault_q      <= fault_d;
            ret_bad_q    <= ret_bad_d;
        end
    end

    assign push_en    = push_en_q;
    assign pop_en     = pop_en_q;
    assign stk_pc     = stk_pc_q;
    assign stk_flags  = stk_flags_q;
    assign pc_load    = pc_load_q;
    assign pc_next    = pc_next_q;
    assign flags_load = flags_load_q;
    assign flags_next = flags_next_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign depth      = depth_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Directed bench for call_ret_ctrl with a behavioural 5-entry return stack.
// Build with +define+STACK_GUARD_EN to exercise the empty-stack guard.
module tb_call_ret_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       call_req, ret_req;
    logic [8:0] call_target, pc;
    logic [3:0] flags;
    logic [8:0] stk_top_pc;
    logic [3:0] stk_top_flags;
    logic       push_en, pop_en, pc_load, flags_load;
    logic [8:0] stk_pc, pc_next;
    logic [3:0] stk_flags, flags_next;
    logic       busy, done, fault;
    logic [2:0] depth;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    call_ret_ctrl dut (
        .clk(clk), .rst(rst),
        .call_req(call_req), .ret_req(ret_req),
        .call_target(call_target), .pc(pc), .flags(flags),
        .stk_top_pc(stk_top_pc), .stk_top_flags(stk_top_flags),
        .push_en(push_en), .pop_en(pop_en),
        .stk_pc(stk_pc), .stk_flags(stk_flags),
        .pc_load(pc_load), .pc_next(pc_next),
        .flags_load(flags_load), .flags_next(flags_next),
        .busy(busy), .done(done), .depth(depth), .fault(fault)
    );

    // Return stack: index cnt-1 is the top, oldest entry dropped when full
    logic [12:0] mem [5];
    int          cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            cnt <= 0;
        end else if (push_en) begin
            if (cnt == 5) begin
                for (int i = 0; i < 4; i++) mem[i] <= mem[i+1];
                mem[4] <= {stk_pc, stk_flags};
            end else begin
                mem[cnt] <= {stk_pc, stk_flags};
                cnt      <= cnt + 1;
            end
        end else if (pop_en && cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    assign stk_top_pc    = (cnt > 0) ? mem[cnt-1][12:4] : 9'h000;
    assign stk_top_flags = (cnt > 0) ? mem[cnt-1][3:0]  : 4'h0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [8:0] p, input logic [3:0] f,
                           input logic [8:0] tgt, input logic [8:0] exp_spc,
                           input logic [2:0] exp_depth);
        pc = p; flags = f; call_target = tgt; call_req = 1'b1;
        tick();
        call_req = 1'b0;
        chk("call_push_en", 16'(push_en), 16'd1);
        chk("call_pop_en", 16'(pop_en), 16'd0);
        chk("call_pc_load", 16'(pc_load), 16'd1);
        chk("call_done", 16'(done), 16'd1);
        chk("call_busy", 16'(busy), 16'd1);
        chk("call_stk_pc", 16'(stk_pc), 16'(exp_spc));
        chk("call_stk_flags", 16'(stk_flags), 16'(f));
        chk("call_pc_next", 16'(pc_next), 16'(tgt));
        chk("call_depth", 16'(depth), 16'(exp_depth));
        tick();
        chk("call_end_push", 16'(push_en), 16'd0);
        chk("call_end_busy", 16'(busy), 16'd0);
    endtask

    task automatic do_ret(input logic [8:0] exp_pc, input logic [3:0] exp_f,
                          input logic [2:0] exp_depth);
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk("ret_pop_en", 16'(pop_en), 16'd1);
        chk("ret_pop_pc_load", 16'(pc_load), 16'd0);
        chk("ret_pop_busy", 16'(busy), 16'd1);
        chk("ret_pop_depth", 16'(depth), 16'(exp_depth));
        tick();
        chk("ret_load_pop", 16'(pop_en), 16'd0);
        chk("ret_load_pc_load", 16'(pc_load), 16'd1);
        chk("ret_load_flags_load", 16'(flags_load), 16'd1);
        chk("ret_load_done", 16'(done), 16'd1);
        chk("ret_load_pc_next", 16'(pc_next), 16'(exp_pc));
        chk("ret_load_flags_next", 16'(flags_next), 16'(exp_f));
        tick();
        chk("ret_end_busy", 16'(busy), 16'd0);
        chk("ret_end_pc_load", 16'(pc_load), 16'd0);
    endtask

    initial begin
        rst = 1'b1; call_req = 1'b0; ret_req = 1'b0;
        call_target = '0; pc = '0; flags = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_depth", 16'(depth), 16'd0);
        chk("rst_pc_next", 16'(pc_next), 16'd0);
        chk("rst_flags_next", 16'(flags_next), 16'd0);
        chk("rst_stk_pc", 16'(stk_pc), 16'd0);
        chk("rst_stk_flags", 16'(stk_flags), 16'd0);
        chk("rst_strobes", 16'({push_en, pop_en, pc_load, flags_load,
                                done, fault}), 16'd0);

        do_call(9'h001, 4'hC, 9'h040, 9'h002, 3'd1);

        do_call(9'h001, 4'h1, 9'h100, 9'h002, 3'd2);
        do_call(9'h003, 4'h2, 9'h101, 9'h004, 3'd3);
        do_call(9'h007, 4'h3, 9'h102, 9'h008, 3'd4);
        do_call(9'h00F, 4'h4, 9'h103, 9'h010, 3'd5);
        do_call(9'h1FE, 4'h5, 9'h104, 9'h1FF, 3'd5);
        do_call(9'h03F, 4'h6, 9'h105, 9'h040, 3'd5);

        do_ret(9'h040, 4'h6, 3'd4);
        do_ret(9'h1FF, 4'h5, 3'd3);
        do_ret(9'h010, 4'h4, 3'd2);
        do_ret(9'h008, 4'h3, 3'd1);
        do_ret(9'h004, 4'h2, 3'd0);

        // RET with an empty stack
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk("empty_depth", 16'(depth), 16'd0);
`ifdef STACK_GUARD_EN
        chk("empty_pop_en", 16'(pop_en), 16'd0);
        chk("empty_fault", 16'(fault), 16'd1);
        tick();
        chk("empty_pc_load", 16'(pc_load), 16'd0);
        chk("empty_flags_load", 16'(flags_load), 16'd0);
        chk("empty_done", 16'(done), 16'd1);
        chk("empty_fault_clr", 16'(fault), 16'd0);
`else
        chk("empty_pop_en", 16'(pop_en), 16'd1);
        chk("empty_fault", 16'(fault), 16'd0);
        tick();
        chk("empty_pc_load", 16'(pc_load), 16'd1);
        chk("empty_done", 16'(done), 16'd1);
        chk("empty_pc_next", 16'(pc_next), 16'h000);
        chk("empty_fault_clr", 16'(fault), 16'd0);
`endif
        tick();
        chk("empty_end_busy", 16'(busy), 16'd0);
        chk("empty_end_depth", 16'(depth), 16'd0);

        do_call(9'h1FF, 4'h9, 9'h0AA, 9'h000, 3'd1);

        // CALL and RET together: CALL wins; RET held while busy is ignored
        pc = 9'h010; flags = 4'hA; call_target = 9'h0BB;
        call_req = 1'b1; ret_req = 1'b1;
        tick();
        call_req = 1'b0;
        chk("both_push_en", 16'(push_en), 16'd1);
        chk("both_pop_en", 16'(pop_en), 16'd0);
        chk("both_stk_pc", 16'(stk_pc), 16'h011);
        chk("both_depth", 16'(depth), 16'd2);
        tick();
        ret_req = 1'b0;
        chk("busy_ret_pop_en", 16'(pop_en), 16'd0);
        chk("busy_ret_busy", 16'(busy), 16'd0);
        chk("busy_ret_depth", 16'(depth), 16'd2);

        // Reset landing during RET_POP
        ret_req = 1'b1;
        tick();
        ret_req = 1'b0;
        chk("abort_pop_en", 16'(pop_en), 16'd1);
        chk("abort_depth_pre", 16'(depth), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_pc_load", 16'(pc_load), 16'd0);
        chk("abort_depth", 16'(depth), 16'd0);
        chk("abort_pop_en_clr", 16'(pop_en), 16'd0);
        tick();
        chk("abort_post_pc_load", 16'(pc_load), 16'd0);
        chk("abort_post_done", 16'(done), 16'd0);
        chk("abort_post_busy", 16'(busy), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_ret_ctrl.md
CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

Interface
REQ-001 SHALL: clk  in  1  system clock; all state changes on the rising edge.
REQ-002 SHALL: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL: call_req  in  1  decoder requests CALL; sampled only in IDLE.
REQ-004 SHALL: ret_req  in  1  decoder requests RET; sampled only in IDLE.
REQ-005 SHALL: call_target  in  9  CALL destination PC.
REQ-006 SHALL: pc  in  9  PC of the current CALL instruction.
REQ-007 SHALL: flags  in  4  current flags.
REQ-008 SHALL: stk_top_pc  in  9  stack top PC, valid one cycle after each push/pop edge.
REQ-009 SHALL: stk_top_flags  in  4  stack top flags.
REQ-010 SHALL: push_en  out  1  one-cycle stack push strobe.
REQ-011 SHALL: pop_en  out  1  one-cycle stack pop strobe.
REQ-012 SHALL: stk_pc  out  9  PC word written on push.
REQ-013 SHALL: stk_flags  out  4  flags word written on push.
REQ-014 SHALL: pc_load  out  1  one-cycle strobe; the core loads pc_next.
REQ-015 SHALL: pc_next  out  9  new PC.
REQ-016 SHALL: flags_load  out  1  one-cycle strobe; the core loads flags_next.
REQ-017 SHALL: flags_next  out  4  restored flags.
REQ-018 SHALL: busy  out  1  high in every state other than IDLE.
REQ-019 SHALL: done  out  1  one-cycle completion pulse.
REQ-020 SHALL: depth  out  3  valid stack entries, range 0..5.
REQ-021 SHALL: fault  out  1  one-cycle RET-on-empty pulse; tied to 0 when STACK_GUARD_EN is undefined.

Function
REQ-022 SHALL: all outputs be registered; FSM states are IDLE, CALL, RET_POP and RET_LOAD.
REQ-023 SHALL: IDLE with call_req=1 -> CALL; capture stk_pc = pc+1 (mod 512), stk_flags = flags, pc_next = call_target.
REQ-024 SHALL: in CALL (1 cycle), push_en = pc_load = done = 1, then -> IDLE; total latency is 1 cycle after acceptance.
REQ-025 SHALL: IDLE with ret_req=1 and call_req=0 -> RET_POP; when call_req and ret_req are both high, CALL wins and ret_req is dropped.
REQ-026 SHALL: in RET_POP (1 cycle), pop_en = 1; capture stk_top_pc and stk_top_flags into pc_next and flags_next in that same cycle (pre-pop top); then -> RET_LOAD.
REQ-027 SHALL: in RET_LOAD (1 cycle), pc_load = flags_load = done = 1, then -> IDLE; total latency is 2 cycles after acceptance.
REQ-028 SHALL: ignore call_req and ret_req while busy=1; requests are not queued.
REQ-029 SHALL: increment depth on every push, saturating at 5; a push at depth 5 keeps depth at 5, because the stack discards its oldest entry.
REQ-030 SHALL: decrement depth on every issued pop; depth never goes below 0.
REQ-031 SHALL: never assert push_en and pop_en in the same cycle.

Reset
REQ-032 SHALL: rst=1 force IDLE with depth=0 and every output 0 (pc_next, flags_next, stk_pc and stk_flags included) on the next edge.
REQ-033 SHALL: rst asserted mid-operation abort the sequence with no further push, pop or load strobes; stack contents are thereafter treated as invalid.

Configuration
REQ-034 SHALL: when STACK_GUARD_EN is defined, a RET accepted at depth=0 -> RET_POP with pop_en=0 and fault=1, then RET_LOAD with pc_load=flags_load=0 and done=1.
REQ-035 SHALL: when STACK_GUARD_EN is undefined, a RET at depth=0 issue pop_en and load the sampled stk_top values normally; depth stays 0 and fault stays 0.

Verification
REQ-036 SHALL: reset, then call_req with pc=0x001, flags=0xC, target=0x040 -> next cycle push_en=1, stk_pc=0x002, stk_flags=0xC, pc_load=1, pc_next=0x040, depth=1.
REQ-037 SHALL: 6 CALLs with pc=0x001,0x003,0x007,0x00F,0x1FE,0x03F -> depth saturates at 5; the 6th push has stk_pc=0x040; the wrap case pc=0x1FF gives stk_pc=0x000.
REQ-038 SHALL: after REQ-037, 5 RETs -> pc_next sequence 0x040, 0x1FF, 0x010, 0x008, 0x004, each with flags_load=1, 2-cycle latency and depth decrementing to 0.
REQ-039 SHALL: call_req and ret_req in the same cycle -> only the CALL executes; ret_req pulsed while busy -> no pop_en.
REQ-040 SHALL: RET at depth 0 -> with STACK_GUARD_EN, fault=1, pop_en=0, pc_load=0, done=1; without it, pop_en=1 and fault=0.
REQ-041 SHALL: rst asserted during RET_POP -> next cycle busy=0, pc_load=0, depth=0.
